mux4_rr_arbiter: RTL
====================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares a single 4:1 multiplexer output channel between four requesters.
- Each requester asserts a request and presents a 1-bit data value.
- The arbiter picks one owner, drives the mux select lines, and holds the grant until the owner releases it or a hold limit expires.
- Sits between the requesters and the mux datapath; it is the mux's only source of select.

Parameters:
- HOLD_MAX, 4, maximum consecutive cycles one owner may hold the grant (legal 1..255).

Ports:
- CLK  input  1  system clock, rising edge active.
- RESET  input  1  asynchronous, active-high reset.
- req  input  4  request lines; bit i belongs to requester i.
- data  input  4  requester data; bit i is requester i's value.
- gnt  output  4  one-hot grant, registered.
- sel  output  2  mux select = index of current owner, registered.
- valid  output  1  high while a grant is active, registered.
- y  output  1  mux output = data[sel] when valid; 0 when not valid (combinational from data).

Behaviour:
- Clocking and reset: one clock, CLK; RESET is asynchronous and active-high.
- Reset values: gnt=4'b0000, sel=2'b00, valid=0, y=0. Internal state: state=IDLE, priority pointer ptr=0, hold counter cnt=0.
- States: IDLE and GRANT.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, at the next edge enter GRANT with owner = first set req bit searching ptr, ptr+1, ... modulo 4.
  - On that edge: gnt=onehot(owner), sel=owner, valid=1, cnt=0.
- Latency: request sampled on edge N gives grant visible after edge N; 1 cycle from req to gnt.
- GRANT, each edge:
  - Release condition: req[owner]==0, or cnt==HOLD_MAX-1.
  - No release: cnt increments; gnt, sel and valid are unchanged.
  - On release: ptr=owner+1 mod 4, so the owner becomes lowest priority.
  - Re-arbitration on release uses the current req with the new ptr.
  - If any req bit is set on release, grant the winner on the same edge (no idle bubble) and clear cnt=0.
  - If no req bit is set on release, go to IDLE: gnt=0, valid=0; sel keeps its last value.
- Sole requester at hold expiry: it is re-granted immediately with cnt=0. Rotation still applies, so valid never drops.
- Simultaneous requests: at most one gnt bit is ever set; gnt is always one-hot or zero.
- Wrap-around: the pointer and the search order wrap 3 -> 0.
- Owner drops req: the drop is sampled at the next edge, so the owner keeps the grant for that final cycle.
- Requests arriving during GRANT do not preempt the owner.
- HOLD_MAX=1: every granted cycle ends in re-arbitration.
- Arithmetic: cnt width is $clog2(HOLD_MAX+1); cnt never exceeds HOLD_MAX-1.
- RESET mid-grant: all outputs go to their reset values immediately, without waiting for CLK. The first grant after reset is searched from ptr=0.
- y path: y = valid & data[sel], fed by the mux sub-module. y has zero latency relative to data changes.

Decomposition:
- Package mux4_arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - localparam N_REQ=4 and SEL_W=2;
  - function next_owner(req, ptr), the rotating priority search.
- One sub-module, mux4_sel_path: combinational 4:1 mux (data, sel -> y) gated by valid.
- The arbiter FSM, pointer and counter stay in the top module.

Test Plan:
- Reset: assert RESET mid-cycle with req=4'b1111 -> gnt=0, valid=0, sel=0, y=0 immediately. After release, the first grant is gnt=4'b0001.
- Single requester: req=4'b0100, data=4'b0100 -> one cycle later gnt=4'b0100, sel=2, y=1. After 4 cycles it is re-granted with no valid gap. Dropping req -> IDLE next edge.
- Full contention: req=4'b1111 held, HOLD_MAX=4 -> owners 0,1,2,3,0 in turn, each for exactly 4 cycles. valid stays 1 and gnt stays one-hot throughout.
- Early release: owner 1 drops req after 2 cycles with req[3]=1 -> same edge gnt=4'b1000, sel=3, cnt restarts.
- Wrap and pointer: owner 3 releases, req=4'b1001 -> next owner 0, not 3. Then owner 0 releases with req=4'b1001 -> owner 3.
- HOLD_MAX=1 build: req=4'b0011 -> gnt alternates 4'b0001 / 4'b0010 every cycle. y tracks data[sel] each cycle.

Source files
------------

// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg: shared types, sizes and the rotating-priority search for the 4:1 mux arbiter
package mux4_arb_pkg;
    typedef enum logic {IDLE, GRANT} arb_state_t;
    localparam int N_REQ = 4;
    localparam int SEL_W = 2;
    function automatic logic [SEL_W-1:0] next_owner(input logic [N_REQ-1:0] req, input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        next_owner = ptr;
        // Scan farthest-first so the closest set bit to ptr is the last one written
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) next_owner = idx;
        end
    endfunction
endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: requester/mux bus between the four requesters and the arbiter
interface mux4_rr_arbiter_if;
    import mux4_arb_pkg::*;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] data;
    logic [N_REQ-1:0] gnt;
    logic [SEL_W-1:0] sel;
    logic             valid;
    logic             y;
    modport master (output req, data, input gnt, sel, valid, y);
    modport slave  (input req, data, output gnt, sel, valid, y);
endinterface

// File: rtl/mux4_sel_path.sv
// mux4_sel_path: 4:1 data mux driven by the arbiter select, forced low when no grant is active
module mux4_sel_path
    import mux4_arb_pkg::*;
(
    input  logic [N_REQ-1:0] data,
    input  logic [SEL_W-1:0] sel,
    input  logic             valid,
    output logic             y
);
    assign y = valid & data[sel];
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin owner selection with hold limit; drives the select of a shared 4:1 mux
module mux4_rr_arbiter
    import mux4_arb_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic CLK,
    input  logic RESET,
    mux4_rr_arbiter_if.slave bus
);
    localparam int CW = $clog2(HOLD_MAX + 1);
    arb_state_t       state, state_n;
    logic [SEL_W-1:0] ptr, ptr_n, sel, sel_n, win;
    logic [CW-1:0]    cnt, cnt_n;
    logic [N_REQ-1:0] gnt, gnt_n;
    logic             valid, valid_n, rel, any;
    logic             y;
    always_comb begin
        any     = |bus.req;
        rel     = !bus.req[sel] || cnt == CW'(HOLD_MAX - 1);
        // On release the search already starts past the outgoing owner
        win     = next_owner(bus.req, state == GRANT ? sel + SEL_W'(1) : ptr);
        state_n = state;
        ptr_n   = ptr;
        sel_n   = sel;
        cnt_n   = cnt;
        gnt_n   = gnt;
        valid_n = valid;
        if (state == IDLE || rel) begin
            if (state == GRANT) ptr_n = sel + SEL_W'(1);
            state_n = any ? GRANT : IDLE;
            sel_n   = any ? win : sel;
            gnt_n   = any ? (N_REQ'(1) << win) : '0;
            valid_n = any;
            cnt_n   = '0;
        end else begin
            cnt_n = cnt + CW'(1);
        end
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            ptr   <= '0;
            sel   <= '0;
            cnt   <= '0;
            gnt   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            valid <= valid_n;
        end
    end
    mux4_sel_path u_sel_path (
        .data  (bus.data),
        .sel   (sel),
        .valid (valid),
        .y     (y)
    );
    assign bus.gnt   = gnt;
    assign bus.sel   = sel;
    assign bus.valid = valid;
    assign bus.y     = y;
endmodule
